// File: rtl/prog_timer_pkg.sv
// Shared types and constants for the multi-channel programmable timer.
// Optional one-shot support is selected by PROG_TIMER_ONESHOT_EN.
package prog_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int unsigned PERIOD_RST_DEF = 50_000_000;

endpackage

// File: rtl/prog_timer_ch.sv
// One timer channel: period, mode, counter and IDLE/RUN state.
// The mode bit only exists when PROG_TIMER_ONESHOT_EN is defined.
module prog_timer_ch
    import prog_timer_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PERIOD_RST = PERIOD_RST_DEF
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic             cfg_oneshot_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             running_o,
    output logic             tick_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oneshot;

`ifdef PROG_TIMER_ONESHOT_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (cfg_we_i && state_q == ST_IDLE) begin
            mode_d = cfg_oneshot_i ? MODE_ONESHOT : MODE_PERIODIC;
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            mode_q <= MODE_PERIODIC;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign oneshot = (mode_q == MODE_ONESHOT);
`else
    logic unused_oneshot;
    assign unused_oneshot = cfg_oneshot_i;
    assign oneshot        = 1'b0;
`endif

    assign running_o = (state_q == ST_RUN);
    assign tick_o    = (state_q == ST_RUN) &&
                       (cnt_q == period_q - CNT_W'(1));

    // Stop has priority over start; start also restarts a running channel.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        if (cfg_we_i && state_q == ST_IDLE) begin
            period_d = cfg_period_i;
        end
        if (stop_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start_i && period_q != '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (tick_o) begin
                cnt_d = '0;
                if (oneshot) begin
                    state_d = ST_IDLE;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q  <= ST_IDLE;
            period_q <= CNT_W'(PERIOD_RST);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// Bank of NUM_CH independent programmable timers sharing one config port.
// Define PROG_TIMER_ONESHOT_EN to enable per-channel one-shot mode.
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PERIOD_RST = PERIOD_RST_DEF
) (
    input  logic                      clk,
    input  logic                      async_nreset,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_period,
    input  logic                      cfg_oneshot,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    output logic [NUM_CH-1:0]         running,
    output logic [NUM_CH-1:0]         tick
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    // Addresses at or above NUM_CH match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        prog_timer_ch #(
            .CNT_W      (CNT_W),
            .PERIOD_RST (PERIOD_RST)
        ) u_ch (
            .clk           (clk),
            .async_nreset  (async_nreset),
            .cfg_we_i      (ch_we),
            .cfg_period_i  (cfg_period),
            .cfg_oneshot_i (cfg_oneshot),
            .start_i       (start[i]),
            .stop_i        (stop[i]),
            .running_o     (running[i]),
            .tick_o        (tick[i])
        );
    end

endmodule

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer (reset period scaled to 20).
// One-shot expectations follow PROG_TIMER_ONESHOT_EN.
module tb_prog_timer;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned PR  = 20;

    logic           clk = 1'b0;
    logic           async_nreset;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic           cfg_oneshot;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] running;
    logic [NCH-1:0] tick;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    prog_timer #(
        .NUM_CH     (NCH),
        .CNT_W      (CW),
        .PERIOD_RST (PR)
    ) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_oneshot  (cfg_oneshot),
        .start        (start),
        .stop         (stop),
        .running      (running),
        .tick         (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [CW-1:0] p,
                             input logic os);
        cfg_ch      = ch;
        cfg_period  = p;
        cfg_oneshot = os;
        cfg_we      = 1'b1;
        @(negedge clk);
        cfg_we      = 1'b0;
    endtask

    // Pulse start for one edge; on return the bench sits in cycle 1.
    task automatic kick(input logic [NCH-1:0] m);
        start = m;
        @(negedge clk);
        start = '0;
    endtask

    initial begin
        async_nreset = 1'b0;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_period   = '0;
        cfg_oneshot  = 1'b0;
        start        = '0;
        stop         = '0;
        repeat (2) @(negedge clk);
        check("rst_running", 32'(running), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        async_nreset = 1'b1;
        @(negedge clk);

        // ch0 at reset period; config write while running is dropped
        kick(4'b0001);
        cfg_ch     = 2'd0;
        cfg_period = 32'd5;
        for (int k = 1; k <= 41; k++) begin
            check("t1_tick0", 32'(tick[0]), 32'(k % 20 == 0));
            check("t1_run0", 32'(running[0]), 32'h1);
            cfg_we = (k == 5);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        stop   = 4'b0001;
        @(negedge clk);
        stop   = '0;
        check("t1_stopped", 32'(running[0]), 32'h0);

        // ch1 periodic P=3, stop sampled at end of cycle 7
        cfg_write(2'd1, 32'd3, 1'b0);
        kick(4'b0010);
        for (int k = 1; k <= 10; k++) begin
            check("t2_tick1", 32'(tick[1]), 32'(k == 3 || k == 6));
            check("t2_run1", 32'(running[1]), 32'(k <= 7));
            stop = (k == 7) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end
        stop = '0;

        // ch2 P=4 one-shot request
        cfg_write(2'd2, 32'd4, 1'b1);
        kick(4'b0100);
        for (int k = 1; k <= 9; k++) begin
`ifdef PROG_TIMER_ONESHOT_EN
            check("t3_tick2", 32'(tick[2]), 32'(k == 4));
            check("t3_run2", 32'(running[2]), 32'(k <= 4));
`else
            check("t3_tick2", 32'(tick[2]), 32'(k == 4 || k == 8));
            check("t3_run2", 32'(running[2]), 32'h1);
`endif
            @(negedge clk);
        end
        stop = 4'b0100;
        @(negedge clk);
        stop = '0;

        // ch3 P=0 never starts
        cfg_write(2'd3, 32'd0, 1'b0);
        kick(4'b1000);
        check("t4_run3_a", 32'(running[3]), 32'h0);
        check("t4_tick3", 32'(tick[3]), 32'h0);
        @(negedge clk);
        check("t4_run3_b", 32'(running[3]), 32'h0);

        // ch1 P=1 ticks every cycle; start+stop together leaves it idle
        cfg_write(2'd1, 32'd1, 1'b0);
        kick(4'b0010);
        for (int k = 1; k <= 4; k++) begin
            check("t5_tick1", 32'(tick[1]), 32'h1);
            check("t5_run1", 32'(running[1]), 32'h1);
            @(negedge clk);
        end
        start = 4'b0010;
        stop  = 4'b0010;
        @(negedge clk);
        start = '0;
        stop  = '0;
        check("t5_ss_run", 32'(running[1]), 32'h0);
        check("t5_ss_tick", 32'(tick[1]), 32'h0);

        // restart in tick cycle (k=3) and mid-count (k=5)
        cfg_write(2'd1, 32'd3, 1'b0);
        kick(4'b0010);
        for (int k = 1; k <= 10; k++) begin
            check("t5_rs_tick", 32'(tick[1]), 32'(k == 3 || k == 8));
            check("t5_rs_run", 32'(running[1]), 32'h1);
            start = (k == 3 || k == 5) ? 4'b0010 : 4'b0000;
            @(negedge clk);
        end
        start = '0;
        stop  = 4'b0010;
        @(negedge clk);
        stop  = '0;

        // async reset mid-count on all channels
        cfg_write(2'd3, 32'd7, 1'b0);
        kick(4'b1111);
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_run", 32'(running), 32'hf);
        check("t6_pre_tick", 32'(tick), 32'h2);
        #2 async_nreset = 1'b0;
        #1;
        check("t6_rst_run", 32'(running), 32'h0);
        check("t6_rst_tick", 32'(tick), 32'h0);
        @(negedge clk);
        async_nreset = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check("t6_quiet_tick", 32'(tick), 32'h0);
            check("t6_quiet_run", 32'(running), 32'h0);
        end
        kick(4'b1110);
        for (int k = 1; k <= 41; k++) begin
            check("t6_per_tick", 32'(tick),
                  (k % 20 == 0) ? 32'he : 32'h0);
            check("t6_per_run", 32'(running), 32'he);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
